// File: rtl/debug_uart_pkg.sv
// Shared constants, FSM state and snapshot layout for the debug telemetry UART.
package debug_uart_pkg;

  localparam logic [7:0] HDR0 = 8'hBE;
  localparam logic [7:0] HDR1 = 8'hEF;
  localparam int PKT_BYTES = 25;
  localparam int IDX_W = $clog2(PKT_BYTES);
  localparam int ADC_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [7:0]                mfg;
    logic [7:0]                dev;
    logic [31:0]               serial;
    logic [7:0]                jack;
    logic [7:0][7:0]           touch;
    logic [3:0][ADC_BITS-1:0]  adc;
  } snap_t;

endpackage

// File: rtl/debug_uart_tx_byte.sv
// 8N1 serializer for one byte; accepts the next byte in the last stop-bit cycle.
module uart_tx_byte
  import debug_uart_pkg::*;
#(
  parameter int DIV = 106
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == '0);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    // counter only reloads at bit boundaries, so timing never drifts
    if (!bit_end) cnt_d = cnt_q - CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_d = ST_START;
          cnt_d   = CNT_MAX;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = CNT_MAX;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = CNT_MAX;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          ready = 1'b1;
          if (valid) begin
            state_d = ST_START;
            cnt_d   = CNT_MAX;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Streams a continuous 25-byte telemetry packet built from a per-packet snapshot.
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int W   = 16,
  parameter int DIV = 106
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tx_o,
  input  logic [W-1:0] adc0,
  input  logic [W-1:0] adc1,
  input  logic [W-1:0] adc2,
  input  logic [W-1:0] adc3,
  input  logic [7:0]   eeprom_mfg,
  input  logic [7:0]   eeprom_dev,
  input  logic [31:0]  eeprom_serial,
  input  logic [7:0]   jack,
  input  logic [7:0]   touch0,
  input  logic [7:0]   touch1,
  input  logic [7:0]   touch2,
  input  logic [7:0]   touch3,
  input  logic [7:0]   touch4,
  input  logic [7:0]   touch5,
  input  logic [7:0]   touch6,
  input  logic [7:0]   touch7
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  logic [W-1:0]          adc_w [4];
  logic [ADC_BITS-1:0]   adc16 [4];
  snap_t                 snap_in, snap_q, snap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            byte_mux;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  hs;

  assign adc_w[0] = adc0;
  assign adc_w[1] = adc1;
  assign adc_w[2] = adc2;
  assign adc_w[3] = adc3;

  for (genvar i = 0; i < 4; i++) begin : g_adc
    if (W > ADC_BITS) begin : g_trunc
      assign adc16[i] = adc_w[i][W-1:W-ADC_BITS];
    end else if (W < ADC_BITS) begin : g_sext
      assign adc16[i] = {{(ADC_BITS-W){adc_w[i][W-1]}}, adc_w[i]};
    end else begin : g_pass
      assign adc16[i] = adc_w[i];
    end
  end

  always_comb begin
    snap_in        = '0;
    snap_in.mfg    = eeprom_mfg;
    snap_in.dev    = eeprom_dev;
    snap_in.serial = eeprom_serial;
    snap_in.jack   = jack;
    snap_in.touch  = {touch7, touch6, touch5, touch4,
                      touch3, touch2, touch1, touch0};
    snap_in.adc    = {adc16[3], adc16[2], adc16[1], adc16[0]};
  end

  assign tx_valid = 1'b1;
  assign hs       = tx_valid && tx_ready;

  // capture lands with the 0xBE start bit; fields are first read at byte 2
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    if (hs) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      if (idx_q == '0) snap_d = snap_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      snap_q <= '0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  always_comb begin
    byte_mux = 8'h00;
    case (idx_q)
      5'd0:  byte_mux = HDR0;
      5'd1:  byte_mux = HDR1;
      5'd2:  byte_mux = snap_q.mfg;
      5'd3:  byte_mux = snap_q.dev;
      5'd4:  byte_mux = snap_q.serial[31:24];
      5'd5:  byte_mux = snap_q.serial[23:16];
      5'd6:  byte_mux = snap_q.serial[15:8];
      5'd7:  byte_mux = snap_q.serial[7:0];
      5'd8:  byte_mux = snap_q.jack;
      5'd9:  byte_mux = snap_q.touch[0];
      5'd10: byte_mux = snap_q.touch[1];
      5'd11: byte_mux = snap_q.touch[2];
      5'd12: byte_mux = snap_q.touch[3];
      5'd13: byte_mux = snap_q.touch[4];
      5'd14: byte_mux = snap_q.touch[5];
      5'd15: byte_mux = snap_q.touch[6];
      5'd16: byte_mux = snap_q.touch[7];
      5'd17: byte_mux = snap_q.adc[0][15:8];
      5'd18: byte_mux = snap_q.adc[0][7:0];
      5'd19: byte_mux = snap_q.adc[1][15:8];
      5'd20: byte_mux = snap_q.adc[1][7:0];
      5'd21: byte_mux = snap_q.adc[2][15:8];
      5'd22: byte_mux = snap_q.adc[2][7:0];
      5'd23: byte_mux = snap_q.adc[3][15:8];
      5'd24: byte_mux = snap_q.adc[3][7:0];
      default: byte_mux = 8'h00;
    endcase
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .data (byte_mux),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (tx_o)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench: decodes the serial stream cycle-exactly and checks packet bytes.
module tb_debug_uart_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx, tx24, tx12;
  logic [15:0] adc0, adc1, adc2, adc3;
  logic [23:0] adc0_24;
  logic [11:0] adc0_12;
  logic [7:0]  mfg, dev, jack;
  logic [31:0] serial;
  logic [7:0]  t0, t1, t2, t3, t4, t5, t6, t7;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] tbl [25];

  always #5 clk = ~clk;

  debug_uart_tx #(.W(16), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .tx_o(tx),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .eeprom_mfg(mfg), .eeprom_dev(dev), .eeprom_serial(serial),
    .jack(jack),
    .touch0(t0), .touch1(t1), .touch2(t2), .touch3(t3),
    .touch4(t4), .touch5(t5), .touch6(t6), .touch7(t7)
  );

  debug_uart_tx #(.W(24), .DIV(DIV)) u_w24 (
    .clk(clk), .rst(rst), .tx_o(tx24),
    .adc0(adc0_24), .adc1(24'h0), .adc2(24'h0), .adc3(24'h0),
    .eeprom_mfg(mfg), .eeprom_dev(dev), .eeprom_serial(serial),
    .jack(jack),
    .touch0(t0), .touch1(t1), .touch2(t2), .touch3(t3),
    .touch4(t4), .touch5(t5), .touch6(t6), .touch7(t7)
  );

  debug_uart_tx #(.W(12), .DIV(DIV)) u_w12 (
    .clk(clk), .rst(rst), .tx_o(tx12),
    .adc0(adc0_12), .adc1(12'h0), .adc2(12'h0), .adc3(12'h0),
    .eeprom_mfg(mfg), .eeprom_dev(dev), .eeprom_serial(serial),
    .jack(jack),
    .touch0(t0), .touch1(t1), .touch2(t2), .touch3(t3),
    .touch4(t4), .touch5(t5), .touch6(t6), .touch7(t7)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge of a frame's first cycle; returns at the next one.
  task automatic read_frame(output logic [7:0] b0, output logic [7:0] b1,
                            output logic [7:0] b2, output logic ok);
    ok = 1'b1;
    b0 = '0;
    b1 = '0;
    b2 = '0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < DIV; c++) begin
        if (bi == 0 && tx !== 1'b0) ok = 1'b0;
        if (bi == 9 && tx !== 1'b1) ok = 1'b0;
        if (bi >= 1 && bi <= 8) begin
          if (c == 0) begin
            b0[bi-1] = tx;
            b1[bi-1] = tx24;
            b2[bi-1] = tx12;
          end else if (tx !== b0[bi-1]) begin
            ok = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    logic       ok;
    logic [7:0] exp;

    tbl = '{8'hBE, 8'hEF, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
            8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'hFF, 8'hFE, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'h00,
            8'h01};

    rst     = 1'b1;
    mfg     = 8'h12;
    dev     = 8'h34;
    serial  = 32'hDEADBEEF;
    jack    = 8'hA5;
    t0 = 8'd0; t1 = 8'd1; t2 = 8'd2; t3 = 8'd3;
    t4 = 8'd4; t5 = 8'd5; t6 = 8'd6; t7 = 8'd7;
    adc0    = 16'hFFFE;
    adc1    = 16'h7FFF;
    adc2    = 16'h8000;
    adc3    = 16'h0001;
    adc0_24 = 24'h123456;
    adc0_12 = 12'h800;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("reset idle %0d", i), 32'(tx), 32'h1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("start after reset", 32'(tx), 32'h0);

    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 25; k++) begin
        if (p == 1 && k == 3) jack = 8'h5A;
        read_frame(b0, b1, b2, ok);
        exp = tbl[k];
        if (p == 2 && k == 8) exp = 8'h5A;
        check($sformatf("pkt%0d byte%0d", p, k), 32'(b0), 32'(exp));
        check($sformatf("pkt%0d frame%0d", p, k), 32'(ok), 32'h1);
        if (p == 0 && k == 17) begin
          check("w24 adc0 hi", 32'(b1), 32'h12);
          check("w12 adc0 hi", 32'(b2), 32'hF8);
        end
        if (p == 0 && k == 18) begin
          check("w24 adc0 lo", 32'(b1), 32'h34);
          check("w12 adc0 lo", 32'(b2), 32'h00);
        end
      end
    end

    for (int k = 0; k < 10; k++) begin
      read_frame(b0, b1, b2, ok);
      exp = (k == 8) ? 8'h5A : tbl[k];
      check($sformatf("pkt3 byte%0d", k), 32'(b0), 32'(exp));
    end
    // byte 10 is 0x01: cycle 2*DIV+1 lies in data bit 1, which is low
    repeat (2 * DIV + 1) @(negedge clk);
    check("byte10 bit1 low", 32'(tx), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("mid reset idle %0d", i), 32'(tx), 32'h1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("restart start bit", 32'(tx), 32'h0);
    read_frame(b0, b1, b2, ok);
    check("restart byte0", 32'(b0), 32'hBE);
    check("restart frame0", 32'(ok), 32'h1);
    read_frame(b0, b1, b2, ok);
    check("restart byte1", 32'(b0), 32'hEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
